// File: rtl/ddr_txn_source.sv
// Request FIFO feeding a DDR controller command port, with MR0 burst-length
// reprogramming that waits for the queue and the controller to drain first.
module ddr_txn_source #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic              cfg_bl_valid,
  input  logic [1:0]        cfg_bl,
  output logic              cfg_ack,
  output logic              act_cmd,
  output logic [ADDR_W-1:0] act_addr,
  output logic [DATA_W-1:0] act_data,
  output logic [1:0]        dev_rw,
  input  logic              next_cmd,
  input  logic              dev_busy,
  input  logic              rw_proc,
  output logic              mrs_update,
  output logic [1:0]        bl_update,
  output logic [4:0]        BL
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_ACK  = 3'd2;
  localparam logic [2:0] MRS_DRAIN = 3'd3;
  localparam logic [2:0] MRS       = 3'd4;

  logic [2:0]        state, state_nx;
  logic [1:0]        rw_mem   [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [CW-1:0]     count;
  logic              cfg_pend;
  logic [1:0]        cfg_code;
  logic              push, pop, drain_ok, have_work;

  assign req_ready = (count < CW'(DEPTH)) && !cfg_pend;
  assign push      = req_valid && req_ready;
  assign pop       = ((state == ISSUE) || (state == WAIT_ACK)) && next_cmd;
  assign drain_ok  = (count == '0) && !rw_proc && !dev_busy;
  assign have_work = (count != '0) && !dev_busy;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (cfg_pend)       state_nx = drain_ok ? MRS : MRS_DRAIN;
        else if (have_work) state_nx = ISSUE;
      end
      MRS_DRAIN: begin
        if (drain_ok)       state_nx = MRS;
        else if (have_work) state_nx = ISSUE;
      end
      ISSUE:    state_nx = next_cmd ? IDLE : WAIT_ACK;
      WAIT_ACK: if (next_cmd) state_nx = IDLE;
      MRS:      state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Storage carries no reset; occupancy is tracked solely by count/pointers.
  always_ff @(posedge clock) begin
    if (push) begin
      rw_mem[wptr]   <= req_rw;
      addr_mem[wptr] <= req_addr;
      data_mem[wptr] <= req_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      if (push) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A new request on the MRS cycle re-arms the pending flag instead of being lost.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cfg_pend <= 1'b0;
      cfg_code <= 2'b00;
    end else if (cfg_bl_valid) begin
      cfg_pend <= 1'b1;
      cfg_code <= cfg_bl;
    end else if (state == MRS) begin
      cfg_pend <= 1'b0;
    end
  end

  // Outputs are decoded from the next state so they are glitch-free flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      act_cmd    <= 1'b0;
      act_addr   <= '0;
      act_data   <= '0;
      dev_rw     <= 2'b00;
      mrs_update <= 1'b0;
      cfg_ack    <= 1'b0;
      bl_update  <= 2'b00;
      BL         <= 5'd8;
    end else begin
      act_cmd    <= (state_nx == ISSUE);
      mrs_update <= (state_nx == MRS);
      cfg_ack    <= (state_nx == MRS);
      if (state_nx == ISSUE) begin
        act_addr <= addr_mem[rptr];
        act_data <= data_mem[rptr];
        dev_rw   <= rw_mem[rptr];
      end
      if (state_nx == MRS) begin
        bl_update <= (cfg_code == 2'b11) ? 2'b00 : cfg_code;
        BL        <= (cfg_code == 2'b10) ? 5'd4 : 5'd8;
      end
    end
  end

endmodule
